// File: rtl/window_pixel_fetch.sv
// -----------------------------------------------------------------------------
// window_pixel_fetch
//
// Maps the VGA scan coordinate onto a row-major image buffer placed at a fixed
// screen origin, with optional power-of-two pixel replication. Issues the
// buffer read, carries the per-pixel flags alongside the memory latency, and
// delivers the final colour with a valid strobe. Outside the window the
// background colour is produced; an optional one-pixel border can be drawn.
//
// Latency from pixel inputs to color/color_valid is MEM_LAT+2 cycles,
// constant for every region. One pixel is accepted every cycle.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   pixel_x/y     current scan column / row (10 bits)
//   pixel_valid   high during active video
//   border_en     enable the window border overlay
//   border_color  border colour, sampled at the output stage
//   addr_out      buffer read address (0 when no read is issued)
//   rd_en         buffer read strobe
//   rd_data       buffer read data, valid MEM_LAT cycles after rd_en
//   color         pixel colour to the DAC
//   color_valid   colour belongs to a valid input pixel
// -----------------------------------------------------------------------------
module window_pixel_fetch #(
    parameter int H_START     = 141,
    parameter int V_START     = 35,
    parameter int IMG_W       = 300,
    parameter int IMG_H       = 300,
    parameter int SCALE_SHIFT = 0,
    parameter int ADDR_W      = 17,
    parameter int COLOR_W     = 8,
    parameter int MEM_LAT     = 1,
    parameter logic [COLOR_W-1:0] BG_COLOR = {COLOR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               pixel_valid,
    input  logic               border_en,
    input  logic [COLOR_W-1:0] border_color,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               rd_en,
    input  logic [COLOR_W-1:0] rd_data,
    output logic [COLOR_W-1:0] color,
    output logic               color_valid
);

    // Inclusive window extent on screen, widened to 32 bits so that a window
    // reaching past column/row 1023 never wraps against the 10-bit inputs.
    localparam logic [31:0] H_FIRST = 32'(H_START);
    localparam logic [31:0] H_LAST  = 32'(H_START + (IMG_W << SCALE_SHIFT) - 1);
    localparam logic [31:0] V_FIRST = 32'(V_START);
    localparam logic [31:0] V_LAST  = 32'(V_START + (IMG_H << SCALE_SHIFT) - 1);
    localparam logic [31:0] IMG_W_L = 32'(IMG_W);

    // Packed flag word travelling alongside the memory read.
    localparam int FLAG_W   = 4;
    localparam int F_VALID  = 0;
    localparam int F_INSIDE = 1;
    localparam int F_BORDER = 2;
    localparam int F_BEN    = 3;

    logic [31:0]         px_s;
    logic [31:0]         py_s;
    logic [31:0]         lx_s;
    logic [31:0]         ly_s;
    logic                in_extent_s;
    logic                inside_s;
    logic                on_border_s;
    logic [ADDR_W-1:0]   addr_s;

    logic                valid_s1_r;
    logic                border_s1_r;
    logic                ben_s1_r;

    logic [FLAG_W-1:0]   flag_pipe_r [MEM_LAT];
    logic [FLAG_W-1:0]   flags_out_s;
    logic [COLOR_W-1:0]  color_nxt_s;

    // Window membership, buffer coordinate and address for the incoming pixel.
    always_comb begin
        px_s        = {22'd0, pixel_x};
        py_s        = {22'd0, pixel_y};
        in_extent_s = (px_s >= H_FIRST) && (px_s <= H_LAST) &&
                      (py_s >= V_FIRST) && (py_s <= V_LAST);
        inside_s    = pixel_valid && in_extent_s;
        lx_s        = (px_s - H_FIRST) >> SCALE_SHIFT;
        ly_s        = (py_s - V_FIRST) >> SCALE_SHIFT;
        if (inside_s) begin
            // Exact inside the window because 2^ADDR_W covers IMG_W*IMG_H.
            addr_s      = ADDR_W'(ly_s * IMG_W_L + lx_s);
            on_border_s = (px_s == H_FIRST) || (px_s == H_LAST) ||
                          (py_s == V_FIRST) || (py_s == V_LAST);
        end else begin
            addr_s      = {ADDR_W{1'b0}};
            on_border_s = 1'b0;
        end
    end

    // Stage 1: issue the buffer read and capture the pixel flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out    <= {ADDR_W{1'b0}};
            rd_en       <= 1'b0;
            valid_s1_r  <= 1'b0;
            border_s1_r <= 1'b0;
            ben_s1_r    <= 1'b0;
        end else begin
            addr_out    <= addr_s;
            rd_en       <= inside_s;
            valid_s1_r  <= pixel_valid;
            border_s1_r <= on_border_s;
            ben_s1_r    <= border_en;
        end
    end

    // Delay the stage-1 flags by MEM_LAT cycles so they meet rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                flag_pipe_r[k] <= {FLAG_W{1'b0}};
            end
        end else begin
            flag_pipe_r[0] <= {ben_s1_r, border_s1_r, rd_en, valid_s1_r};
            for (int k = 1; k < MEM_LAT; k++) begin
                flag_pipe_r[k] <= flag_pipe_r[k-1];
            end
        end
    end

    assign flags_out_s = flag_pipe_r[MEM_LAT-1];

    // Output colour selection from the delayed flags.
    always_comb begin
        color_nxt_s = {COLOR_W{1'b0}};
        if (!flags_out_s[F_VALID]) begin
            color_nxt_s = {COLOR_W{1'b0}};
        end else if (!flags_out_s[F_INSIDE]) begin
            color_nxt_s = BG_COLOR;
        end else if (flags_out_s[F_BORDER] && flags_out_s[F_BEN]) begin
            color_nxt_s = border_color;
        end else begin
            color_nxt_s = rd_data;
        end
    end

    // Output register towards the DAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color       <= {COLOR_W{1'b0}};
            color_valid <= 1'b0;
        end else begin
            color       <= color_nxt_s;
            color_valid <= flags_out_s[F_VALID];
        end
    end

endmodule

// File: tb/tb_window_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_window_pixel_fetch
//
// Three instances share one stimulus stream:
//   dut0 defaults, dut1 SCALE_SHIFT=1, dut2 MEM_LAT=3.
// Each instance gets its own latency-accurate buffer model whose data is a
// fixed function of the address. A history of every cycle's inputs feeds a
// screen-level model that predicts addr_out/rd_en/color/color_valid of every
// instance on every cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_window_pixel_fetch;

    localparam int HMAX = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        border_en;
    logic [7:0]  border_color;

    logic [16:0] addr_o [3];
    logic        rd_o   [3];
    logic [7:0]  rd_d   [3];
    logic [7:0]  col_o  [3];
    logic        cv_o   [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         hx    [HMAX];
    int         hy    [HMAX];
    bit         hv    [HMAX];
    bit         hben  [HMAX];
    bit         hrst  [HMAX];
    logic [7:0] hbcol [HMAX];

    always #5 clk = ~clk;

    // Buffer contents: a fixed function of the address.
    function automatic logic [7:0] memf(input logic [16:0] a);
        memf = a[7:0] + 8'h74;
    endfunction

    function automatic int s_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int l_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_cfg
            localparam int S = (g == 1) ? 1 : 0;
            localparam int L = (g == 2) ? 3 : 1;
            logic [16:0] ma [L];
            logic        mv [L];

            window_pixel_fetch #(
                .SCALE_SHIFT(S),
                .MEM_LAT(L)
            ) u_dut (
                .clk(clk),
                .rst_n(rst_n),
                .pixel_x(pixel_x),
                .pixel_y(pixel_y),
                .pixel_valid(pixel_valid),
                .border_en(border_en),
                .border_color(border_color),
                .addr_out(addr_o[g]),
                .rd_en(rd_o[g]),
                .rd_data(rd_d[g]),
                .color(col_o[g]),
                .color_valid(cv_o[g])
            );

            // Buffer with L cycles of read latency; garbage when not read.
            always @(posedge clk) begin
                ma[0] <= addr_o[g];
                mv[0] <= rd_o[g];
                for (int k = 1; k < L; k++) begin
                    ma[k] <= ma[k-1];
                    mv[k] <= mv[k-1];
                end
            end

            assign rd_d[g] = mv[L-1] ? memf(ma[L-1]) : 8'hA5;
        end
    endgenerate

    // Screen-level view of one pixel for a given scale.
    task automatic model(input int x, input int y, input bit v, input int s,
                         output bit ins, output int addr, output bit brd);
        int xl;
        int yl;
        xl   = 141 + 300 * (1 << s) - 1;
        yl   = 35 + 300 * (1 << s) - 1;
        ins  = v && (x >= 141) && (x <= xl) && (y >= 35) && (y <= yl);
        addr = ins ? ((y - 35) / (1 << s)) * 300 + (x - 141) / (1 << s) : 0;
        brd  = ins && ((x == 141) || (x == xl) || (y == 35) || (y == yl));
    endtask

    // True when cycles a..b all exist and none of them saw reset.
    function automatic bit clean(input int a, input int b);
        if (a < 0) return 1'b0;
        for (int k = a; k <= b; k++) begin
            if (hrst[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Record this cycle's inputs and compare every instance with the model.
    task automatic check_cycle();
        bit ins;
        bit brd;
        int addr;
        int m;
        int e_addr;
        int e_rd;
        int e_col;
        int e_cv;
        hx[cyc]    = int'(pixel_x);
        hy[cyc]    = int'(pixel_y);
        hv[cyc]    = pixel_valid;
        hben[cyc]  = border_en;
        hbcol[cyc] = border_color;
        hrst[cyc]  = !rst_n;
        for (int i = 0; i < 3; i++) begin
            m = cyc - 1;
            e_addr = 0;
            e_rd   = 0;
            if (clean(m, cyc)) begin
                model(hx[m], hy[m], hv[m], s_of(i), ins, addr, brd);
                e_addr = addr;
                e_rd   = int'(ins);
            end
            m = cyc - l_of(i) - 2;
            e_col = 0;
            e_cv  = 0;
            if (clean(m, cyc) && hv[m]) begin
                model(hx[m], hy[m], 1'b1, s_of(i), ins, addr, brd);
                e_cv = 1;
                if (!ins) e_col = 0;
                else if (brd && hben[m]) e_col = int'(hbcol[cyc-1]);
                else e_col = int'(memf(17'(addr)));
            end
            chk("addr_out", i, int'(addr_o[i]), e_addr);
            chk("rd_en", i, int'(rd_o[i]), e_rd);
            chk("color", i, int'(col_o[i]), e_col);
            chk("color_valid", i, int'(cv_o[i]), e_cv);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, end just after
    // the next rising edge.
    task automatic step(input int x, input int y, input bit v, input bit rst);
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        pixel_valid = v;
        rst_n       = !rst;
        @(negedge clk);
        if (cyc < HMAX) check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stage1_lit(input int i, input int x, input int y,
                              input int e_addr, input int e_rd);
        step(x, y, 1'b1, 1'b0);
        chk("lit_addr", i, int'(addr_o[i]), e_addr);
        chk("lit_rd_en", i, int'(rd_o[i]), e_rd);
    endtask

    task automatic color_lit(input int i, input int x, input int y, input int e_col);
        step(x, y, 1'b1, 1'b0);
        repeat (l_of(i) + 1) step(0, 0, 1'b0, 1'b0);
        chk("lit_color", i, int'(col_o[i]), e_col);
        chk("lit_color_valid", i, int'(cv_o[i]), 1);
    endtask

    initial begin : stim
        bit ins;
        bit brd;
        int addr;
        int xs[9];
        int ys[9];
        xs = '{140, 141, 142, 439, 440, 441, 739, 740, 741};
        ys = '{34, 35, 36, 333, 334, 335, 633, 634, 635};
        border_en    = 1'b0;
        border_color = 8'h00;

        // Pin the model with hand-computed values.
        model(440, 334, 1'b1, 0, ins, addr, brd);
        chk("model_addr_last", -1, addr, 89999);
        model(740, 634, 1'b1, 1, ins, addr, brd);
        chk("model_addr_scaled", -1, addr, 89999);
        model(300, 334, 1'b1, 0, ins, addr, brd);
        chk("model_border", -1, int'(brd), 1);
        model(441, 100, 1'b1, 0, ins, addr, brd);
        chk("model_outside", -1, int'(ins), 0);

        repeat (3) step(0, 0, 1'b0, 1'b1);
        chk("reset_color_valid", 0, int'(cv_o[0]), 0);
        repeat (2) step(0, 0, 1'b0, 1'b0);

        // First window pixel: address 0 one cycle later, data at latency 3.
        stage1_lit(0, 141, 35, 0, 1);
        repeat (2) step(0, 0, 1'b0, 1'b0);
        chk("lit_first_color", 0, int'(col_o[0]), 8'h74);
        chk("lit_first_valid", 0, int'(cv_o[0]), 1);

        stage1_lit(0, 440, 35, 299, 1);
        stage1_lit(0, 141, 36, 300, 1);
        stage1_lit(0, 440, 334, 89999, 1);
        stage1_lit(0, 441, 100, 0, 0);
        stage1_lit(0, 140, 100, 0, 0);
        color_lit(0, 441, 100, 8'h00);
        color_lit(0, 140, 100, 8'h00);

        // Border overlay.
        border_en    = 1'b1;
        border_color = 8'hE0;
        color_lit(0, 141, 100, 8'hE0);
        color_lit(0, 300, 334, 8'hE0);
        color_lit(0, 142, 36, 8'hA1);
        border_en = 1'b0;
        color_lit(0, 141, 100, 8'hA0);

        // Pixel replication.
        stage1_lit(1, 143, 37, 301, 1);
        stage1_lit(1, 740, 634, 89999, 1);
        stage1_lit(1, 741, 100, 0, 0);

        // Back-to-back inside pixels through the long-latency instance.
        for (int k = 0; k < 10; k++) begin
            step(150 + k, 40, 1'b1, 1'b0);
            if (k == 5) chk("lit_stream", 2, int'(col_o[2]), 8'h5A);
        end
        repeat (6) step(0, 0, 1'b0, 1'b0);

        // Reset pulse in the middle of a stream.
        for (int k = 0; k < 12; k++) begin
            step(200 + k, 50, 1'b1, k == 5);
            if (k == 5) chk("lit_rst_flush", 2, int'(cv_o[2]), 0);
        end
        repeat (6) step(0, 0, 1'b0, 1'b0);

        // Edge sweep with a changing border colour and enable.
        for (int xi = 0; xi < 9; xi++) begin
            for (int yi = 0; yi < 9; yi++) begin
                border_en    = ((xi + yi) % 2) == 1;
                border_color = 8'(xi * 16 + yi + 1);
                step(xs[xi], ys[yi], 1'b1, 1'b0);
            end
        end
        repeat (6) step(0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
